zuc_eea3_framer: RTL

Upstream framing stage for the 128-EEA3 confidentiality datapath. It accepts one command per message, carrying COUNT, BEARER, DIRECTION, CK and LENGTH in bits, plus an unframed 32-bit word stream. From these it drives the EEA3 block's control channel, then the data stream with `last`/`keep` derived from LENGTH. It sits directly in front of `zuc_eea3`, so the cipher core needs no knowledge of message length.

---
 rtl/zuc_eea3_framer_if.sv | 55 +++++
 rtl/zuc_eea3_framer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/zuc_eea3_framer_if.sv
// Command, input-stream, EEA3-control and EEA3-data channels of the framer.
// The master view is the framer itself; the slave view is its surroundings.
interface zuc_eea3_framer_if #(
   parameter int unsigned bw = 8,
   parameter int unsigned lw = 32
);
   localparam int unsigned kw = 32 / bw;

   logic            s_cmd_valid;
   logic            s_cmd_ready;
   logic [31:0]     s_cmd_count;
   logic [4:0]      s_cmd_bearer;
   logic            s_cmd_direction;
   logic [127:0]    s_cmd_ck;
   logic [lw-1:0]   s_cmd_length;

   logic            s_valid;
   logic            s_ready;
   logic [31:0]     s_data;

   logic            m_ctl_valid;
   logic            m_ctl_ready;
   logic [31:0]     m_ctl_count;
   logic [4:0]      m_ctl_bearer;
   logic            m_ctl_direction;
   logic [127:0]    m_ctl_ck;

   logic            m_valid;
   logic            m_ready;
   logic            m_last;
   logic [31:0]     m_data;
   logic [kw-1:0]   m_keep;

   modport master (
      input  s_cmd_valid, s_cmd_count, s_cmd_bearer, s_cmd_direction, s_cmd_ck, s_cmd_length,
      output s_cmd_ready,
      input  s_valid, s_data,
      output s_ready,
      output m_ctl_valid, m_ctl_count, m_ctl_bearer, m_ctl_direction, m_ctl_ck,
      input  m_ctl_ready,
      output m_valid, m_last, m_data, m_keep,
      input  m_ready
   );

   modport slave (
      output s_cmd_valid, s_cmd_count, s_cmd_bearer, s_cmd_direction, s_cmd_ck, s_cmd_length,
      input  s_cmd_ready,
      output s_valid, s_data,
      input  s_ready,
      input  m_ctl_valid, m_ctl_count, m_ctl_bearer, m_ctl_direction, m_ctl_ck,
      output m_ctl_ready,
      input  m_valid, m_last, m_data, m_keep,
      output m_ready
   );
endinterface

// File: rtl/zuc_eea3_framer.sv
// Framing stage ahead of zuc_eea3: turns a length-tagged command plus an
// unframed word stream into one control beat and a last/keep-annotated stream.
module zuc_eea3_framer #(
   parameter int unsigned bw = 8,
   parameter int unsigned lw = 32
) (
   input  logic              clk,
   input  logic              resetn,
   zuc_eea3_framer_if.master bus
);
   localparam int unsigned KW = 32 / bw;
   localparam int unsigned CW = lw - 4;

   typedef enum logic [1:0] {IDLE, CTL, DATA} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   words_q, words_d;
   logic [KW-1:0]   last_keep_q, last_keep_d;
   logic [31:0]     count_q, count_d;
   logic [4:0]      bearer_q, bearer_d;
   logic            direction_q, direction_d;
   logic [127:0]    ck_q, ck_d;

   logic [4:0]      rem;
   logic [CW-1:0]   cmd_words;
   logic [KW-1:0]   cmd_keep;
   logic            word_last;

   assign rem = bus.s_cmd_length[4:0];
   // ceil(length/32) without ever widening the length itself
   assign cmd_words = CW'(bus.s_cmd_length[lw-1:5]) + CW'(rem != 5'd0);
   assign word_last = (words_q == CW'(1));

   // Lane i of the final word carries data when it starts below rem
   always_comb begin : keep_calc
      cmd_keep = '0;
      for (int unsigned i = 0; i < KW; i++) begin
         cmd_keep[i] = (rem == 5'd0) || ((i * bw) < 32'(rem));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin : state_reg
      if (!resetn) begin
         state_q     <= IDLE;
         words_q     <= '0;
         last_keep_q <= '0;
         count_q     <= '0;
         bearer_q    <= '0;
         direction_q <= 1'b0;
         ck_q        <= '0;
      end else begin
         state_q     <= state_d;
         words_q     <= words_d;
         last_keep_q <= last_keep_d;
         count_q     <= count_d;
         bearer_q    <= bearer_d;
         direction_q <= direction_d;
         ck_q        <= ck_d;
      end
   end

   always_comb begin : fsm_comb
      state_d         = state_q;
      words_d         = words_q;
      last_keep_d     = last_keep_q;
      count_d         = count_q;
      bearer_d        = bearer_q;
      direction_d     = direction_q;
      ck_d            = ck_q;
      bus.s_cmd_ready = 1'b0;
      bus.m_ctl_valid = 1'b0;
      bus.s_ready     = 1'b0;
      bus.m_valid     = 1'b0;
      bus.m_last      = 1'b0;
      bus.m_keep      = '0;

      case (state_q)
         IDLE: begin
            bus.s_cmd_ready = 1'b1;
            if (bus.s_cmd_valid) begin
               count_d     = bus.s_cmd_count;
               bearer_d    = bus.s_cmd_bearer;
               direction_d = bus.s_cmd_direction;
               ck_d        = bus.s_cmd_ck;
               words_d     = cmd_words;
               last_keep_d = cmd_keep;
               // Zero-length messages are swallowed without a control beat
               if (bus.s_cmd_length != '0) begin
                  state_d = CTL;
               end
            end
         end
         CTL: begin
            bus.m_ctl_valid = 1'b1;
            if (bus.m_ctl_ready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            bus.m_valid = bus.s_valid;
            bus.s_ready = bus.m_ready;
            bus.m_last  = word_last;
            bus.m_keep  = word_last ? last_keep_q : '1;
            if (bus.s_valid && bus.m_ready) begin
               words_d = words_q - CW'(1);
               if (word_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.m_data          = bus.s_data;
   assign bus.m_ctl_count     = count_q;
   assign bus.m_ctl_bearer    = bearer_q;
   assign bus.m_ctl_direction = direction_q;
   assign bus.m_ctl_ck        = ck_q;
endmodule
